// File: rtl/acc_control_unit.sv
// acc_control_unit: adaptive-cruise controller FSM with hysteresis, latched emergency braking and door interlock
// Ports: clk/rst_n (async active-low reset); engage, door_open; speed_limit, car_speed [SPEED_W];
//        leading_distance [DIST_W]; unlock_doors, accelerate_car, brake_car, emergency_brake; state_o [3]
module acc_control_unit #(
  parameter int SPEED_W       = 8,
  parameter int DIST_W        = 7,
  parameter int MIN_DISTANCE  = 40,
  parameter int SAFE_DISTANCE = 20,
  parameter int HYST          = 2,
  parameter int UNLOCK_DELAY  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               engage,
  input  logic               door_open,
  input  logic [SPEED_W-1:0] speed_limit,
  input  logic [SPEED_W-1:0] car_speed,
  input  logic [DIST_W-1:0]  leading_distance,
  output logic               unlock_doors,
  output logic               accelerate_car,
  output logic               brake_car,
  output logic               emergency_brake,
  output logic [2:0]         state_o
);
  localparam int CW = (UNLOCK_DELAY < 1) ? 1 : $clog2(UNLOCK_DELAY + 1);
  localparam logic [CW-1:0]      UD     = CW'(UNLOCK_DELAY);
  localparam logic [SPEED_W:0]   HYST_X = (SPEED_W + 1)'(HYST);
  localparam logic [DIST_W-1:0]  MIN_D  = DIST_W'(MIN_DISTANCE);
  localparam logic [DIST_W-1:0]  SAFE_D = DIST_W'(SAFE_DISTANCE);
  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_ACCEL  = 3'd1,
    ST_CRUISE = 3'd2,
    ST_DECEL  = 3'd3,
    ST_EBRAKE = 3'd4
  } state_t;
  state_t        r_cs, w_ns;
  logic [CW-1:0] r_cnt;
  logic [SPEED_W:0] w_spd, w_lim;
  logic w_far, w_danger, w_slow, w_fast, w_stopped, w_go;
  // Sums are one bit wider than the speeds so limit/speed near full scale cannot wrap
  assign w_spd     = {1'b0, car_speed};
  assign w_lim     = {1'b0, speed_limit};
  assign w_stopped = car_speed == '0;
  assign w_far     = leading_distance >= MIN_D;
  assign w_danger  = leading_distance < SAFE_D && !w_stopped;
  assign w_slow    = w_spd + HYST_X < w_lim;
  assign w_fast    = w_spd > w_lim + HYST_X;
  assign w_go      = engage && w_far;
  always_comb begin
    w_ns = ST_STOP;
    case (r_cs)
      ST_STOP:   w_ns = w_go && !door_open ? ST_ACCEL : ST_STOP;
      ST_ACCEL:  w_ns = !w_go ? ST_DECEL : car_speed >= speed_limit ? ST_CRUISE : ST_ACCEL;
      ST_CRUISE: w_ns = !w_go || w_fast ? ST_DECEL : w_slow ? ST_ACCEL : ST_CRUISE;
      ST_DECEL:  w_ns = w_stopped ? ST_STOP : w_go && w_slow ? ST_ACCEL :
                        w_go && car_speed <= speed_limit ? ST_CRUISE : ST_DECEL;
      ST_EBRAKE: w_ns = w_stopped ? ST_STOP : ST_EBRAKE;
      default:   w_ns = ST_STOP;
    endcase
    // Danger overrides everything except the already-latched emergency state
    if (w_danger && r_cs != ST_EBRAKE) w_ns = ST_EBRAKE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs  <= ST_STOP;
      r_cnt <= '0;
    end else begin
      r_cs  <= w_ns;
      // Count standstill cycles spent in STOP; any motion or departure relocks
      r_cnt <= r_cs == ST_STOP && w_ns == ST_STOP && w_stopped ? (r_cnt == UD ? r_cnt : r_cnt + 1'b1) : '0;
    end
  end
  assign unlock_doors    = r_cs == ST_STOP && r_cnt == UD;
  assign accelerate_car  = r_cs == ST_ACCEL;
  assign brake_car       = r_cs == ST_DECEL || r_cs == ST_EBRAKE;
  assign emergency_brake = r_cs == ST_EBRAKE;
  assign state_o         = r_cs;
endmodule

// File: tb/tb_acc_control_unit.sv
// tb_acc_control_unit: directed-vector self-checking bench for acc_control_unit
module tb_acc_control_unit;
  logic       clk, rst_n, engage, door_open;
  logic [7:0] speed_limit, car_speed;
  logic [6:0] leading_distance;
  logic       unlock_doors, accelerate_car, brake_car, emergency_brake;
  logic [2:0] state_o;
  int n_tot = 0;
  int n_bad = 0;
  acc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .engage(engage), .door_open(door_open),
    .speed_limit(speed_limit), .car_speed(car_speed), .leading_distance(leading_distance),
    .unlock_doors(unlock_doors), .accelerate_car(accelerate_car), .brake_car(brake_car),
    .emergency_brake(emergency_brake), .state_o(state_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // outs packs {unlock, accel, brake, ebrake}
  task automatic chk_all(input string tag, input logic [2:0] st, input logic [3:0] outs);
    chk({tag, ".state"}, {5'd0, state_o}, {5'd0, st});
    chk({tag, ".outs"}, {4'd0, unlock_doors, accelerate_car, brake_car, emergency_brake}, {4'd0, outs});
  endtask
  task automatic step_spd(input string tag, input logic [7:0] spd, input logic [2:0] st, input logic [3:0] outs);
    car_speed = spd;
    tick();
    chk_all(tag, st, outs);
  endtask
  initial begin
    rst_n = 1'b0; engage = 1'b0; door_open = 1'b0;
    speed_limit = 8'd60; car_speed = 8'd0; leading_distance = 7'd100;
    #3;
    chk_all("reset", 3'd0, 4'b0000);
    #4 rst_n = 1'b1;
    tick(); chk_all("unlock_e1", 3'd0, 4'b0000);
    tick(); chk_all("unlock_e2", 3'd0, 4'b0000);
    tick(); chk_all("unlock_e3", 3'd0, 4'b0000);
    tick(); chk_all("unlock_e4", 3'd0, 4'b1000);
    engage = 1'b1; door_open = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("door_hold", 3'd0, 4'b1000);
    end
    door_open = 1'b0;
    tick(); chk_all("depart", 3'd1, 4'b0100);
    step_spd("hy_59", 8'd59, 3'd1, 4'b0100);
    step_spd("hy_60", 8'd60, 3'd2, 4'b0000);
    step_spd("hy_62", 8'd62, 3'd2, 4'b0000);
    step_spd("hy_63", 8'd63, 3'd3, 4'b0010);
    step_spd("hy_58", 8'd58, 3'd2, 4'b0000);
    step_spd("hy_63b", 8'd63, 3'd3, 4'b0010);
    step_spd("hy_57", 8'd57, 3'd1, 4'b0100);
    speed_limit = 8'd50;
    step_spd("cr_50", 8'd50, 3'd2, 4'b0000);
    leading_distance = 7'd19;
    tick(); chk_all("eb_enter", 3'd4, 4'b0011);
    leading_distance = 7'd100;
    tick(); chk_all("eb_latch", 3'd4, 4'b0011);
    step_spd("eb_stop", 8'd0, 3'd0, 4'b0000);
    engage = 1'b0;
    tick(); chk_all("re_e1", 3'd0, 4'b0000);
    tick(); tick(); chk_all("re_e3", 3'd0, 4'b0000);
    tick(); chk_all("re_e4", 3'd0, 4'b1000);
    step_spd("relock", 8'd5, 3'd0, 4'b0000);
    engage = 1'b1; leading_distance = 7'd10;
    tick(); chk_all("danger_wins", 3'd4, 4'b0011);
    leading_distance = 7'd100;
    step_spd("eb_stop2", 8'd0, 3'd0, 4'b0000);
    speed_limit = 8'd255;
    tick(); chk_all("ov_go", 3'd1, 4'b0100);
    step_spd("ov_acc254", 8'd254, 3'd1, 4'b0100);
    step_spd("ov_cr255", 8'd255, 3'd2, 4'b0000);
    step_spd("ov_254", 8'd254, 3'd2, 4'b0000);
    step_spd("ov_255", 8'd255, 3'd2, 4'b0000);
    speed_limit = 8'd100;
    step_spd("ar_accel", 8'd50, 3'd1, 4'b0100);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 3'd0, 4'b0000);
    #2 rst_n = 1'b1;
    car_speed = 8'd0; engage = 1'b0;
    tick(); chk_all("post_rst", 3'd0, 4'b0000);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/acc_control_unit.md
Name: acc_control_unit

Overview:
- Parametrised adaptive-cruise controller; next generation of the car control FSM.
- Adds generic speed/distance widths, a CRUISE state with speed hysteresis, an EBRAKE emergency state, a driver engage input and a door-open interlock.
- Doors unlock only after the car has been at standstill in STOP for a programmable number of cycles.
- Sits between the vehicle sensor block (speed, radar distance) and the actuator drivers.

Parameters:
- SPEED_W, 8, width of speed_limit and car_speed.
- DIST_W, 7, width of leading_distance.
- MIN_DISTANCE, 40, follow distance (DIST_W bits); below it the car must not accelerate.
- SAFE_DISTANCE, 20, emergency threshold (DIST_W bits); must be less than MIN_DISTANCE.
- HYST, 2, speed hysteresis band (SPEED_W bits).
- UNLOCK_DELAY, 4, standstill cycles in STOP before unlock_doors asserts (0 means immediate).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- engage  in  1  driver cruise-enable.
- door_open  in  1  any door open; blocks departure.
- speed_limit  in  SPEED_W  target/maximum speed.
- car_speed  in  SPEED_W  measured speed.
- leading_distance  in  DIST_W  distance to the leading vehicle.
- unlock_doors  out  1  door unlock command.
- accelerate_car  out  1  throttle request.
- brake_car  out  1  normal brake request.
- emergency_brake  out  1  full brake request.
- state_o  out  3  current state code.

Behaviour:
- State encoding: STOP=0, ACCEL=1, CRUISE=2, DECEL=3, EBRAKE=4. Codes 5-7 are illegal; their next state is STOP and all their outputs are 0.
- Registers: cs (3 bits) and stop_cnt (clog2(UNLOCK_DELAY+1) bits, minimum 1).
  - Asynchronous reset (rst_n=0): cs=STOP, stop_cnt=0.
  - Leaving reset is synchronous to the next clk edge.
- Outputs are a Moore decode of cs and stop_cnt only, with no combinational path from inputs.
  - Reset values: all outputs 0, state_o=0.
- Output decode:
  - STOP: unlock_doors = (stop_cnt==UNLOCK_DELAY); all other outputs 0.
  - ACCEL: accelerate_car=1.
  - CRUISE: all command outputs 0.
  - DECEL: brake_car=1.
  - EBRAKE: emergency_brake=1 and brake_car=1.
- Arithmetic: all sums are formed at SPEED_W+1 bits so there is no wrap. Definitions:
  - far = leading_distance >= MIN_DISTANCE.
  - danger = (leading_distance < SAFE_DISTANCE) && (car_speed != 0).
  - slow = car_speed + HYST < speed_limit.
  - fast = car_speed > speed_limit + HYST.
- Next state, evaluated in priority order:
  1. Any state other than EBRAKE with danger goes to EBRAKE.
  2. STOP: goes to ACCEL if engage && far && !door_open; otherwise stays in STOP.
  3. ACCEL:
     - goes to DECEL if !engage || !far;
     - else goes to CRUISE if car_speed >= speed_limit;
     - else stays in ACCEL.
  4. CRUISE:
     - goes to DECEL if !engage || !far || fast;
     - else goes to ACCEL if slow;
     - else stays in CRUISE.
  5. DECEL:
     - goes to STOP if car_speed==0;
     - else goes to ACCEL if engage && far && slow;
     - else goes to CRUISE if engage && far && car_speed <= speed_limit;
     - else stays in DECEL.
  6. EBRAKE: goes to STOP if car_speed==0; otherwise stays. EBRAKE is latched: distance recovery does not exit it.
- stop_cnt, updated each edge:
  - If cs==STOP, next state==STOP and car_speed==0: stop_cnt increments, saturating at UNLOCK_DELAY.
  - Otherwise stop_cnt clears to 0.
- Boundary conditions:
  - Entering STOP gives unlock_doors=0 until UNLOCK_DELAY further standstill edges have occurred.
  - car_speed nonzero while in STOP clears the counter and relocks the doors.
  - door_open only inhibits STOP to ACCEL; it never forces a transition.
  - engage and danger asserted together: danger wins.
  - Reset asserted mid-EBRAKE returns to STOP immediately.

Test Plan:
- Reset release with engage=0, speed=0, dist=100 -> state_o=0 stays; unlock_doors=0 for edges 1-3 and 1 after the 4th edge.
- STOP with engage=1, dist=100, door_open=1 for 3 cycles, then door_open=0 -> state stays STOP, then ACCEL one edge after door_open drops; accelerate_car=1 and unlock_doors=0.
- Hysteresis, limit=60: ACCEL at speed 59 stays; speed 60 -> CRUISE; speed 62 stays CRUISE; speed 63 -> DECEL; speed 58 -> CRUISE; then (starting from DECEL again) speed 57 -> ACCEL.
- In CRUISE at speed 50, dist drops to 19 -> EBRAKE next edge with emergency_brake=1 and brake_car=1; dist back to 100 -> stays EBRAKE; speed 0 -> STOP.
- Overflow, limit=255, HYST=2, CRUISE at speed 254 then 255 -> stays CRUISE, no ACCEL and no DECEL.
- Async reset pulse mid-ACCEL between clock edges -> state_o=0 and accelerate_car=0 immediately, before the next edge.
